// File: rtl/uart_pkg.sv
// Shared types, defaults and the oversampling divider calculation for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_STOP_BITS  = 2;

    // Clocks per oversampling tick, rounded to nearest and never below 1.
    function automatic int calc_div(input int clk_freq, input int baudrate, input int oversample);
        int denom;
        int div;
        denom = baudrate * oversample;
        div   = (clk_freq + (denom / 2)) / denom;
        if (div < 1) begin
            div = 1;
        end
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Serial input and received-word outputs of the UART receiver.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic                  rx_din;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rx_valid;
    logic                  frame_err;
    logic                  rx_busy;

    // Line driver / word consumer side.
    modport master (
        output rx_din,
        input  data_out,
        input  rx_valid,
        input  frame_err,
        input  rx_busy
    );

    // Receiver side.
    modport slave (
        input  rx_din,
        output data_out,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// Free-running oversampling tick generator; clr realigns its phase to a start edge.
module uart_rx_tick_gen import uart_pkg::*; #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUDRATE   = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUDRATE, OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == CNT_LAST);
    assign tick   = w_tick;

    // Count 0..DIV-1, wrapping on the tick and restarting from 0 on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizer, 3-sample majority voter, frame FSM and shift register.
module uart_rx_core import uart_pkg::*; #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUDRATE   = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int STOP_BITS  = DEF_STOP_BITS
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_core_if.slave  rx_if
);

    localparam int M     = OVERSAMPLE / 2;
    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [IDX_W-1:0] IDX_PRE  = IDX_W'(M - 1);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(M);
    localparam logic [IDX_W-1:0] IDX_DEC  = IDX_W'(M + 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [1:0]       STOP_LAST = 2'(STOP_BITS - 1);

    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_hist;
    logic                  w_fall;
    logic                  w_tick;
    logic                  w_clr;
    logic                  w_maj;
    logic                  w_err_next;

    rx_state_t             r_state;
    logic [IDX_W-1:0]      r_tick_idx;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [1:0]            r_stop_cnt;
    logic [1:0]            r_samp;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_stop_err;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_ferr;
    logic                  r_busy;

    // Two-flop synchronizer plus history flop; all idle-high after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= rx_if.rx_din;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_fall = r_hist & ~r_sync2;
    assign w_clr  = (r_state == IDLE) && w_fall;

    uart_rx_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUDRATE   (BAUDRATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    // 2-of-3 vote: two stored samples plus the line value at the decision tick.
    assign w_maj      = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_sync2) | (r_samp[1] & r_sync2);
    assign w_err_next = r_stop_err | ~w_maj;

    // Frame FSM with registered strobes, data and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_tick_idx <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_samp     <= '0;
            r_shift    <= '0;
            r_stop_err <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (w_fall) begin
                        r_state    <= START;
                        r_tick_idx <= '0;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= '0;
                        r_stop_err <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_tick_idx <= (r_tick_idx == IDX_END) ? '0 : r_tick_idx + 1'b1;
                        if (r_tick_idx == IDX_PRE) begin
                            r_samp[0] <= r_sync2;
                        end
                        if (r_tick_idx == IDX_MID) begin
                            r_samp[1] <= r_sync2;
                        end
                        if (r_tick_idx == IDX_DEC) begin
                            case (r_state)
                                START: begin
                                    if (w_maj) begin
                                        r_state <= IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                end
                                DATA: begin
                                    r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                                end
                                STOP: begin
                                    r_stop_err <= w_err_next;
                                    if (r_stop_cnt == STOP_LAST) begin
                                        // Leave at mid-bit so a back-to-back start edge is not missed.
                                        r_state <= IDLE;
                                        r_busy  <= 1'b0;
                                        if (w_err_next) begin
                                            r_ferr <= 1'b1;
                                        end else begin
                                            r_data  <= r_shift;
                                            r_valid <= 1'b1;
                                        end
                                    end else begin
                                        r_stop_cnt <= r_stop_cnt + 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        if (r_tick_idx == IDX_END) begin
                            case (r_state)
                                START: r_state <= DATA;
                                DATA: begin
                                    if (r_bit_cnt == BIT_LAST) begin
                                        r_state <= STOP;
                                    end else begin
                                        r_bit_cnt <= r_bit_cnt + 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign rx_if.data_out  = r_data;
    assign rx_if.rx_valid  = r_valid;
    assign rx_if.frame_err = r_ferr;
    assign rx_if.rx_busy   = r_busy;

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive counterpart to the existing UART transmit path.
- Recovers 8N2-style frames from an asynchronous serial line: one start bit, DATA_WIDTH data bits LSB-first, STOP_BITS stop bits.
- Samples the line at OVERSAMPLE x baud with 3-sample majority voting.
- Presents each received word with a one-cycle valid strobe, or flags a framing error.
- Runs entirely on the system clock; contains its own oversampling tick generator.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUDRATE, 9600: line bit rate.
- OVERSAMPLE, 16: ticks per bit; must be >= 8 and even.
- DATA_WIDTH, 8: data bits per frame.
- STOP_BITS, 2: stop bits checked per frame (1 or 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_din  in  1  serial input, idle high, asynchronous to clk.
- data_out  out  DATA_WIDTH  last correctly received word.
- rx_valid  out  1  one-cycle pulse; data_out updated this cycle.
- frame_err  out  1  one-cycle pulse; a stop bit sampled 0.
- rx_busy  out  1  high from start-edge detection until return to IDLE.

Behaviour:
- Reset values: data_out=0, rx_valid=0, frame_err=0, rx_busy=0. Synchronizer flops reset to 1. FSM resets to IDLE and all counters to 0. Reset mid-frame abandons the frame with no strobe.
- Input path: 2-flop synchronizer, plus one history flop for edge detection.
- Tick generator:
  - Free-running counter 0..DIV-1, DIV = round(CLK_FREQ/(BAUDRATE*OVERSAMPLE)), minimum 1.
  - tick is a one-clk pulse when count == DIV-1.
- Bit timing:
  - tick_idx counts 0..OVERSAMPLE-1 within each bit.
  - Samples are taken at tick_idx M-1, M and M+1, where M = OVERSAMPLE/2.
  - The bit decision is the 2-of-3 majority, taken at tick_idx M+1.
  - The bit ends at tick_idx OVERSAMPLE-1.
- FSM states and transitions:
  - IDLE: wait for a synced falling edge (history 1, current 0). On the edge, clear tick_idx and the tick divider phase, then go to START. A line stuck low does not retrigger.
  - START: at the decision point, majority 1 means a false start: go to IDLE with no strobe. Majority 0 means continue to DATA at the end of the bit.
  - DATA: each decision shifts into the shift register LSB-first. After DATA_WIDTH bits, go to STOP at the end of the bit.
  - STOP: each stop decision must be 1; any 0 sets an error flag. At the decision point of the last stop bit, go to IDLE immediately. Not waiting for the bit end allows resync to a back-to-back next start edge.
- Outputs on leaving STOP (registered, the clk after the final decision):
  - If no stop bit sampled 0: data_out is loaded from the shift register and rx_valid=1 for one clk.
  - Otherwise: frame_err=1 for one clk and data_out holds its previous value.
- rx_valid and frame_err are never high together.
- Latency: start edge to strobe = ((1+DATA_WIDTH+STOP_BITS-1)*OVERSAMPLE + M+1) ticks, +2 clk for the synchronizer, +1 clk for output registration.
- There is no backpressure. A new word overwrites data_out; the consumer must capture it on rx_valid.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP}.
  - Function computing DIV from CLK_FREQ/BAUDRATE/OVERSAMPLE.
  - Shared defaults DATA_WIDTH=8, STOP_BITS=2.
- Sub-module uart_rx_tick_gen (params CLK_FREQ, BAUDRATE, OVERSAMPLE):
  - Ports clk, rst_n, clr (phase realign on start edge), tick.
- Synchronizer, majority voter, FSM and shift register stay in uart_rx_core.

Test Plan:
- Bench parameters for all scenarios: CLK_FREQ=1_600_000, BAUDRATE=10_000, OVERSAMPLE=16, so DIV=10 and one bit = 160 clk.
- 1. Send 0xA5 with 2 stop bits -> exactly one rx_valid pulse, data_out=0xA5, frame_err never high. Pulse arrives 169 ticks (+3 clk ±10 clk) after the start edge. rx_busy returns to 0.
- 2. Drive rx_din low for 30 clk, then high -> no rx_valid and no frame_err; rx_busy drops within about 100 clk; a following 0x3C frame is received correctly.
- 3. After scenario 1, send 0x3C with the second stop bit driven 0 -> one frame_err pulse, no rx_valid, data_out remains 0xA5.
- 4. Send 0x00 then 0xFF back-to-back, the second start bit immediately after the second stop bit -> two rx_valid pulses with data_out 0x00 then 0xFF, no frame_err.
- 5. Assert rst_n low for 5 clk after 4 data bits of 0xC3 -> all outputs 0 during reset and no strobe for 0xC3. Then send 0x5A -> rx_valid with data_out=0x5A.
- 6. Send 0x81 with a 10-clk inverted glitch on tick_idx 7 of data bit 3 -> majority vote rejects it: rx_valid with data_out=0x81.
